// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: each accepted command becomes one AXI read or write,
// and the result returns on the response port with the AXI response code and latency.
module axi4_lite_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LAT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [LAT_WIDTH-1:0]    rsp_cycles,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp
);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

  state_t                  state, state_nxt;
  logic                    cmd_ready_nxt, awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic [ADDR_WIDTH-1:0]   awaddr_nxt, araddr_nxt;
  logic [DATA_WIDTH-1:0]   wdata_nxt, rsp_rdata_nxt;
  logic                    rsp_valid_nxt, rsp_write_nxt;
  logic [1:0]              rsp_resp_nxt;
  logic [LAT_WIDTH-1:0]    rsp_cycles_nxt, cnt, cnt_nxt, cnt_inc;

  assign awprot = 3'b000;
  assign arprot = 3'b000;
  assign wstrb  = '1;

  // cnt counts the accept cycle as 1, so the response latency is cnt_inc on the retiring edge
  assign cnt_inc = (cnt == {LAT_WIDTH{1'b1}}) ? cnt : cnt + LAT_WIDTH'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      wdata      <= '0;
      araddr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_resp   <= '0;
      rsp_cycles <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      cmd_ready  <= cmd_ready_nxt;
      awvalid    <= awvalid_nxt;
      wvalid     <= wvalid_nxt;
      bready     <= bready_nxt;
      arvalid    <= arvalid_nxt;
      rready     <= rready_nxt;
      awaddr     <= awaddr_nxt;
      wdata      <= wdata_nxt;
      araddr     <= araddr_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_write  <= rsp_write_nxt;
      rsp_rdata  <= rsp_rdata_nxt;
      rsp_resp   <= rsp_resp_nxt;
      rsp_cycles <= rsp_cycles_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cmd_ready_nxt  = cmd_ready;
    awvalid_nxt    = awvalid;
    wvalid_nxt     = wvalid;
    bready_nxt     = bready;
    arvalid_nxt    = arvalid;
    rready_nxt     = rready;
    awaddr_nxt     = awaddr;
    wdata_nxt      = wdata;
    araddr_nxt     = araddr;
    rsp_valid_nxt  = rsp_valid;
    rsp_write_nxt  = rsp_write;
    rsp_rdata_nxt  = rsp_rdata;
    rsp_resp_nxt   = rsp_resp;
    rsp_cycles_nxt = rsp_cycles;
    cnt_nxt        = cnt_inc;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_nxt = 1'b0;
          cnt_nxt       = LAT_WIDTH'(1);
          rsp_write_nxt = cmd_write;
          if (cmd_write) begin
            state_nxt   = WR;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
          end else begin
            state_nxt   = RA;
            arvalid_nxt = 1'b1;
            araddr_nxt  = cmd_addr;
          end
        end
      end
      // AW and W retire independently; a ready seen with its valid already low changes nothing
      WR: begin
        awvalid_nxt = awvalid && !awready;
        wvalid_nxt  = wvalid && !wready;
        if (!awvalid_nxt && !wvalid_nxt) begin
          state_nxt  = WB;
          bready_nxt = 1'b1;
        end
      end
      WB: begin
        if (bvalid) begin
          bready_nxt     = 1'b0;
          rsp_resp_nxt   = bresp;
          rsp_rdata_nxt  = '0;
          rsp_valid_nxt  = 1'b1;
          rsp_cycles_nxt = cnt_inc;
          state_nxt      = RSP;
        end
      end
      RA: begin
        if (arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD;
        end
      end
      RD: begin
        if (rvalid) begin
          rready_nxt     = 1'b0;
          rsp_resp_nxt   = rresp;
          rsp_rdata_nxt  = rdata;
          rsp_valid_nxt  = 1'b1;
          rsp_cycles_nxt = cnt_inc;
          state_nxt      = RSP;
        end
      end
      RSP: begin
        cnt_nxt = '0;
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Randomized scoreboard bench for axi4_lite_master: a reactive memory slave with per-command
// timing, a response monitor popping expectations, and a memory reference model.
module tb_axi4_lite_master;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int LW = 5;
  localparam int LAT_MAX = (1 << LW) - 1;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [DW-1:0]   cmd_wdata = '0;
  logic            rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic [LW-1:0]   rsp_cycles;
  logic            awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;

  typedef struct {
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            d1, d2, d3;
    logic [1:0]    resp;
  } slave_t;

  typedef struct {
    bit            write;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    int            cycles;
    int            stall;
  } exp_t;

  slave_t        slave_q[$];
  exp_t          exp_q[$];
  logic [DW-1:0] model_mem[4];
  logic [DW-1:0] slave_mem[4];
  int            n_compared = 0;
  int            n_mismatched = 0;

  axi4_lite_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAT_WIDTH(LW)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic clearSlave();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid  = 1'b0; bresp  = 2'b00;
    rvalid  = 1'b0; rresp  = 2'b00; rdata = '0;
  endtask

  // Readies and responses that the master must ignore because nothing matches them
  task automatic slaveNoise();
    awready = 1'($urandom_range(0, 1));
    wready  = 1'($urandom_range(0, 1));
    arready = 1'($urandom_range(0, 1));
    bvalid  = 1'($urandom_range(0, 1));
    bresp   = 2'($urandom_range(0, 3));
    rvalid  = 1'($urandom_range(0, 1));
    rresp   = 2'($urandom_range(0, 3));
    rdata   = DW'($urandom);
  endtask

  task automatic slaveWrite();
    slave_t        t;
    bit            aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    int            ca = 0, cw = 0, guard = 0;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_data = '0;
    if (slave_q.size() == 0) begin
      failNow("slave_unexpected_write");
      return;
    end
    t = slave_q.pop_front();
    checkOutput("txn_kind_write", 64'(arvalid), 64'(!t.write));
    checkOutput("cmd_ready_busy", 64'(cmd_ready), 64'h0);
    while (!(aw_done && w_done)) begin
      checkOutput("awvalid_hold", 64'(awvalid), 64'(!aw_done));
      checkOutput("wvalid_hold", 64'(wvalid), 64'(!w_done));
      if (!aw_done) checkOutput("awaddr", 64'(awaddr), 64'(t.addr));
      if (!w_done) begin
        checkOutput("wdata", 64'(wdata), 64'(t.data));
        checkOutput("wstrb", 64'(wstrb), 64'hF);
      end
      awready = !aw_done && (ca >= t.d1);
      wready  = !w_done && (cw >= t.d2);
      arready = 1'($urandom_range(0, 1));
      bvalid  = 1'($urandom_range(0, 1));
      rvalid  = 1'($urandom_range(0, 1));
      aw_hs = awready && awvalid;
      w_hs  = wready && wvalid;
      if (aw_hs) cap_addr = awaddr;
      if (w_hs) cap_data = wdata;
      @(posedge clk); #1;
      if (!resetn) begin clearSlave(); return; end
      if (aw_hs) aw_done = 1'b1; else if (!aw_done) ca++;
      if (w_hs) w_done = 1'b1; else if (!w_done) cw++;
      guard++;
      if (guard > 300) begin failNow("write_addr_data_timeout"); clearSlave(); return; end
    end
    clearSlave();
    for (int k = 0; k <= t.d3; k++) begin
      checkOutput("bready_high", 64'(bready), 64'h1);
      if (k == t.d3) begin
        bvalid = 1'b1; bresp = t.resp; rvalid = 1'b0;
      end else begin
        bvalid = 1'b0; rvalid = 1'($urandom_range(0, 1)); rdata = DW'($urandom);
      end
      @(posedge clk); #1;
      if (!resetn) begin clearSlave(); return; end
    end
    clearSlave();
    checkOutput("bready_single_pulse", 64'(bready), 64'h0);
    if (t.resp == 2'b00) slave_mem[cap_addr[3:2]] = cap_data;
  endtask

  task automatic slaveRead();
    slave_t        t;
    bit            hs;
    int            ca = 0;
    logic [AW-1:0] cap_addr = '0;
    if (slave_q.size() == 0) begin
      failNow("slave_unexpected_read");
      return;
    end
    t = slave_q.pop_front();
    checkOutput("txn_kind_read", 64'(arvalid), 64'(!t.write));
    forever begin
      checkOutput("arvalid_hold", 64'(arvalid), 64'h1);
      checkOutput("araddr", 64'(araddr), 64'(t.addr));
      checkOutput("arprot", 64'(arprot), 64'h0);
      arready = (ca >= t.d1);
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      bvalid  = 1'($urandom_range(0, 1));
      hs = arready && arvalid;
      if (hs) cap_addr = araddr;
      @(posedge clk); #1;
      if (!resetn) begin clearSlave(); return; end
      if (hs) break;
      ca++;
      if (ca > 300) begin failNow("read_addr_timeout"); clearSlave(); return; end
    end
    clearSlave();
    checkOutput("arvalid_drop", 64'(arvalid), 64'h0);
    for (int k = 0; k <= t.d2; k++) begin
      checkOutput("rready_high", 64'(rready), 64'h1);
      if (k == t.d2) begin
        rvalid = 1'b1; rdata = slave_mem[cap_addr[3:2]]; rresp = t.resp; bvalid = 1'b0;
      end else begin
        rvalid = 1'b0; bvalid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (!resetn) begin clearSlave(); return; end
    end
    clearSlave();
    checkOutput("rready_single_pulse", 64'(rready), 64'h0);
  endtask

  initial begin : slave
    clearSlave();
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin clearSlave(); continue; end
      if (awvalid || wvalid) slaveWrite();
      else if (arvalid) slaveRead();
      else slaveNoise();
    end
  end

  initial begin : monitor
    exp_t e;
    bit   have = 1'b0, retired = 1'b0;
    int   wait_left = 0;
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin rsp_ready = 1'b0; have = 1'b0; retired = 1'b0; continue; end
      if (retired) begin
        checkOutput("cmd_ready_after_retire", 64'(cmd_ready), 64'h1);
        checkOutput("rsp_valid_after_retire", 64'(rsp_valid), 64'h0);
        retired = 1'b0;
        rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        if (!have) begin
          if (exp_q.size() == 0) begin
            failNow("unexpected_response");
            rsp_ready = 1'b1;
            continue;
          end
          e = exp_q.pop_front();
          have = 1'b1;
          wait_left = e.stall;
        end
        checkOutput("rsp_write", 64'(rsp_write), 64'(e.write));
        checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        checkOutput("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        checkOutput("rsp_cycles", 64'(rsp_cycles), 64'(e.cycles));
        checkOutput("cmd_ready_during_rsp", 64'(cmd_ready), 64'h0);
        checkOutput("axi_quiet_during_rsp", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'h0);
        if (wait_left > 0) begin
          rsp_ready = 1'b0;
          wait_left--;
        end else begin
          rsp_ready = 1'b1;
          have = 1'b0;
          retired = 1'b1;
        end
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  // Queues the slave timing and the model's expected response, then offers the command
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input int d1, input int d2, input int d3, input logic [1:0] resp,
                               input int stall, input bit expect_rsp);
    slave_t s;
    exp_t   e;
    int     lat, guard = 0;
    bit     seen;
    s.write = wr; s.addr = addr; s.data = data; s.d1 = d1; s.d2 = d2; s.d3 = d3; s.resp = resp;
    slave_q.push_back(s);
    lat = wr ? 3 + ((d1 > d2) ? d1 : d2) + d3 : 3 + d1 + d2;
    if (lat > LAT_MAX) lat = LAT_MAX;
    if (expect_rsp) begin
      e.write = wr; e.resp = resp; e.cycles = lat; e.stall = stall;
      if (wr) begin
        e.rdata = '0;
        if (resp == 2'b00) model_mem[addr[3:2]] = data;
      end else begin
        e.rdata = model_mem[addr[3:2]];
      end
      exp_q.push_back(e);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    forever begin
      seen = cmd_ready;
      @(posedge clk); #1;
      if (seen) break;
      guard++;
      if (guard > 400) begin failNow("cmd_accept_timeout"); break; end
    end
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) failNow("drain_timeout");
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin : stimulus
    bit            wr, big;
    logic [AW-1:0] a;
    logic [DW-1:0] dat;
    logic [1:0]    rs;
    int            d1, d2, d3, st;
    for (int i = 0; i < 4; i++) begin
      model_mem[i] = DW'($urandom);
      slave_mem[i] = model_mem[i];
    end
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'h1);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("reset_rsp_cycles", 64'(rsp_cycles), 64'h0);
    checkOutput("reset_axi_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed: write with split AW/W timing, slow read, error response");
    applyStimulus(1'b1, 4'h4, 32'hDEADBEEF, 0, 3, 0, 2'b00, 0, 1'b1);
    drain();
    model_mem[2] = 32'h12345678;
    slave_mem[2] = 32'h12345678;
    applyStimulus(1'b0, 4'h8, 32'h0, 0, 4, 0, 2'b00, 0, 1'b1);
    applyStimulus(1'b1, 4'h0, 32'hCAFE0001, 1, 0, 2, 2'b10, 0, 1'b1);
    applyStimulus(1'b0, 4'h0, 32'h0, 0, 0, 0, 2'b00, 0, 1'b1);

    $display("[TB] directed: response backpressure, back-to-back write/read, latency saturation");
    applyStimulus(1'b0, 4'h4, 32'h0, 0, 0, 0, 2'b00, 10, 1'b1);
    applyStimulus(1'b1, 4'hC, 32'hA5A5A5A5, 0, 0, 0, 2'b00, 0, 1'b1);
    applyStimulus(1'b0, 4'hC, 32'h0, 0, 0, 0, 2'b00, 0, 1'b1);
    applyStimulus(1'b0, 4'h8, 32'h0, 13, 15, 0, 2'b00, 0, 1'b1);
    applyStimulus(1'b0, 4'h8, 32'h0, 14, 14, 0, 2'b00, 0, 1'b1);
    applyStimulus(1'b1, 4'h4, 32'h0BADF00D, 20, 5, 20, 2'b01, 0, 1'b1);
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = AW'($urandom_range(0, 3) * 4);
      dat = DW'($urandom);
      big = ($urandom_range(0, 7) == 0);
      d1  = big ? $urandom_range(4, 16) : $urandom_range(0, 3);
      d2  = big ? $urandom_range(4, 16) : $urandom_range(0, 3);
      d3  = $urandom_range(0, 3);
      rs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      st  = $urandom_range(0, 3);
      applyStimulus(wr, a, dat, d1, d2, d3, rs, st, 1'b1);
    end
    drain();
    checkOutput("slave_queue_consumed", 64'(slave_q.size()), 64'h0);

    $display("[TB] directed: reset during an address/data phase");
    applyStimulus(1'b1, 4'h4, 32'h11112222, 8, 8, 0, 2'b00, 0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("awvalid_before_reset", 64'(awvalid), 64'h1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("awvalid_async_reset", 64'(awvalid), 64'h0);
    checkOutput("wvalid_async_reset", 64'(wvalid), 64'h0);
    checkOutput("cmd_ready_async_reset", 64'(cmd_ready), 64'h1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    checkOutput("cmd_ready_post_reset", 64'(cmd_ready), 64'h1);
    checkOutput("rsp_valid_post_reset", 64'(rsp_valid), 64'h0);
    applyStimulus(1'b0, 4'h4, 32'h0, 0, 1, 0, 2'b00, 0, 1'b1);
    applyStimulus(1'b1, 4'h8, 32'h5A5A0F0F, 2, 0, 1, 2'b00, 1, 1'b1);
    applyStimulus(1'b0, 4'h8, 32'h0, 1, 0, 0, 2'b00, 0, 1'b1);
    drain();
    checkOutput("slave_queue_final", 64'(slave_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    failNow("global_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
